// File: rtl/conv_pkg.sv
// Shared definitions for the convolution output path: tile/data sizing and
// the writer FSM state encoding.
package conv_pkg;

    localparam int IN_DATA_WIDTH      = 8;
    localparam int KERNEL_DATA_WIDTH  = 8;
    localparam int ACC_GUARD_BITS     = 13;
    localparam int OUT_DATA_WIDTH_DEF = IN_DATA_WIDTH + KERNEL_DATA_WIDTH + ACC_GUARD_BITS;
    localparam int OUT_TILE_DEF       = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_t;

    // Counter width that stays >= 1 bit even for a single-value range.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/output_addr_gen.sv
// Tile position (tr, tc) and in-tile element (r, c) counters, and the raster
// BRAM address of the element currently selected.
module output_addr_gen
    import conv_pkg::*;
#(
    parameter int OUT_TILE         = OUT_TILE_DEF,
    parameter int OUT_IMAGE_WIDTH  = 8,
    parameter int OUT_IMAGE_HEIGHT = 8,
    parameter int ADDR_WIDTH       = 15,
    localparam int EW              = cnt_width(OUT_TILE * OUT_TILE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  elem_step_i,
    input  logic                  tile_step_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [EW-1:0]         elem_idx_o,
    output logic                  last_elem_o,
    output logic                  last_tile_o
);

    localparam int TX = OUT_IMAGE_WIDTH / OUT_TILE;
    localparam int TY = OUT_IMAGE_HEIGHT / OUT_TILE;
    localparam int RW = cnt_width(OUT_TILE);
    localparam int XW = cnt_width(TX);
    localparam int YW = cnt_width(TY);

    logic [RW-1:0] r_q, c_q;
    logic [XW-1:0] tc_q;
    logic [YW-1:0] tr_q;

    assign last_elem_o = (r_q == RW'(OUT_TILE - 1)) && (c_q == RW'(OUT_TILE - 1));
    assign last_tile_o = (tr_q == YW'(TY - 1)) && (tc_q == XW'(TX - 1));

    assign elem_idx_o = EW'(32'(r_q) * 32'(OUT_TILE) + 32'(c_q));
    assign addr_o     = ADDR_WIDTH'((32'(tr_q) * 32'(OUT_TILE) + 32'(r_q)) * 32'(OUT_IMAGE_WIDTH)
                                    + 32'(tc_q) * 32'(OUT_TILE) + 32'(c_q));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q  <= '0;
            c_q  <= '0;
            tc_q <= '0;
            tr_q <= '0;
        end else begin
            if (elem_step_i) begin
                if (c_q == RW'(OUT_TILE - 1)) begin
                    c_q <= '0;
                    r_q <= (r_q == RW'(OUT_TILE - 1)) ? '0 : r_q + RW'(1);
                end else begin
                    c_q <= c_q + RW'(1);
                end
            end
            if (tile_step_i) begin
                if (tc_q == XW'(TX - 1)) begin
                    tc_q <= '0;
                    tr_q <= (tr_q == YW'(TY - 1)) ? '0 : tr_q + YW'(1);
                end else begin
                    tc_q <= tc_q + XW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/output_tile_writer.sv
// Captures one PE output tile per handshake and streams its elements into the
// output image BRAM in raster position, one write per cycle.
//
// state    | meaning
// ST_IDLE  | ready for a tile; handshake captures data and starts writing
// ST_WRITE | one element written per cycle, k = 0 .. OUT_TILE^2-1
// ST_DONE  | tile_done (and frame_done on last tile) pulse; tile position advances
module output_tile_writer
    import conv_pkg::*;
#(
    parameter int OUT_TILE         = OUT_TILE_DEF,
    parameter int OUT_DATA_WIDTH   = OUT_DATA_WIDTH_DEF,
    parameter int OUT_IMAGE_WIDTH  = 8,
    parameter int OUT_IMAGE_HEIGHT = 8,
    parameter int ADDR_WIDTH       = 15
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [OUT_TILE*OUT_TILE*OUT_DATA_WIDTH-1:0] i_tile_data,
    input  logic                                       i_tile_valid,
    output logic                                       o_tile_ready,
    output logic                                       o_bram_en,
    output logic                                       o_bram_we,
    output logic [ADDR_WIDTH-1:0]                      o_bram_addr,
    output logic [OUT_DATA_WIDTH-1:0]                  o_bram_din,
    output logic                                       o_tile_done,
    output logic                                       o_frame_done
);

    localparam int NE = OUT_TILE * OUT_TILE;
    localparam int EW = cnt_width(NE);

    wr_state_t                 state_q;
    logic [OUT_DATA_WIDTH-1:0] elem_q [NE];
    logic                      ready_q, wr_q, tile_done_q, frame_done_q;
    logic                      last_elem, last_tile;
    logic [EW-1:0]             elem_idx;

    output_addr_gen #(
        .OUT_TILE        (OUT_TILE),
        .OUT_IMAGE_WIDTH (OUT_IMAGE_WIDTH),
        .OUT_IMAGE_HEIGHT(OUT_IMAGE_HEIGHT),
        .ADDR_WIDTH      (ADDR_WIDTH)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .elem_step_i(state_q == ST_WRITE),
        .tile_step_i(state_q == ST_DONE),
        .addr_o     (o_bram_addr),
        .elem_idx_o (elem_idx),
        .last_elem_o(last_elem),
        .last_tile_o(last_tile)
    );

    assign o_tile_ready = ready_q;
    assign o_bram_en    = wr_q;
    assign o_bram_we    = wr_q;
    assign o_bram_din   = elem_q[elem_idx];
    assign o_tile_done  = tile_done_q;
    assign o_frame_done = frame_done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b0;
            wr_q         <= 1'b0;
            tile_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < NE; i++) elem_q[i] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (i_tile_valid && ready_q) begin
                        for (int i = 0; i < NE; i++)
                            elem_q[i] <= i_tile_data[i*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
                        ready_q <= 1'b0;
                        wr_q    <= 1'b1;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (last_elem) begin
                        wr_q         <= 1'b0;
                        tile_done_q  <= 1'b1;
                        frame_done_q <= last_tile;
                        state_q      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    tile_done_q  <= 1'b0;
                    frame_done_q <= 1'b0;
                    ready_q      <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    wr_q    <= 1'b0;
                    ready_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_tile_writer.sv
// Randomized scoreboard bench for output_tile_writer: a tile-level model
// predicts every BRAM write and done pulse; a monitor compares on each strobe.
module tb_output_tile_writer;

    localparam int T  = 2;
    localparam int DW = 29;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int AW = 15;
    localparam int TW = T * T * DW;
    localparam int TX = W / T;
    localparam int TY = H / T;

    logic          clk, reset;
    logic [TW-1:0] i_tile_data;
    logic          i_tile_valid;
    logic          o_tile_ready, o_bram_en, o_bram_we, o_tile_done, o_frame_done;
    logic [AW-1:0] o_bram_addr;
    logic [DW-1:0] o_bram_din;

    output_tile_writer #(
        .OUT_TILE(T), .OUT_DATA_WIDTH(DW), .OUT_IMAGE_WIDTH(W),
        .OUT_IMAGE_HEIGHT(H), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .i_tile_data(i_tile_data), .i_tile_valid(i_tile_valid),
        .o_tile_ready(o_tile_ready), .o_bram_en(o_bram_en), .o_bram_we(o_bram_we),
        .o_bram_addr(o_bram_addr), .o_bram_din(o_bram_din),
        .o_tile_done(o_tile_done), .o_frame_done(o_frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            last;
        bit            frame;
    } wr_exp_t;

    wr_exp_t exp_q[$];
    int      n_checks = 0;
    int      n_fail   = 0;
    int      tile_n   = 0;
    bit      pending_done = 0;
    bit      expect_write = 0;
    bit      exp_frame    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the n-th tile of a frame sits at raster tile position (n / TX, n % TX).
    task automatic model_push(input logic [TW-1:0] d);
        int tr, tc;
        wr_exp_t e;
        tr = tile_n / TX;
        tc = tile_n % TX;
        for (int r = 0; r < T; r++) begin
            for (int c = 0; c < T; c++) begin
                e.addr  = AW'((tr * T + r) * W + tc * T + c);
                e.data  = d[(r * T + c) * DW +: DW];
                e.last  = (r == T - 1) && (c == T - 1);
                e.frame = (tile_n == TX * TY - 1);
                exp_q.push_back(e);
            end
        end
        tile_n = (tile_n + 1) % (TX * TY);
    endtask

    function automatic logic [TW-1:0] rand_tile();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[TW-1:0];
    endfunction

    task automatic send_tile(input logic [TW-1:0] d, input bit hold_valid);
        int w;
        w = 0;
        @(negedge clk);
        while (!o_tile_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!o_tile_ready) begin
            check("ready_timeout", 64'(o_tile_ready), 64'(1));
            return;
        end
        i_tile_data  = d;
        i_tile_valid = 1'b1;
        model_push(d);
        @(posedge clk);
        #1;
        check("ready_after_accept", 64'(o_tile_ready), 64'(0));
        i_tile_data = rand_tile();
        if (!hold_valid) i_tile_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        i_tile_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"},    64'(o_bram_en),    64'(0));
        check({tag, "_we"},    64'(o_bram_we),    64'(0));
        check({tag, "_addr"},  64'(o_bram_addr),  64'(0));
        check({tag, "_din"},   64'(o_bram_din),   64'(0));
        check({tag, "_done"},  64'(o_tile_done),  64'(0));
        check({tag, "_frame"}, 64'(o_frame_done), 64'(0));
        check({tag, "_ready"}, 64'(o_tile_ready), 64'(0));
    endtask

    // Monitor: compares every presented write and done pulse against the scoreboard.
    initial begin
        wr_exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pending_done = 0;
                expect_write = 0;
            end else begin
                if (pending_done) begin
                    check("tile_done", 64'(o_tile_done), 64'(1));
                    check("frame_done", 64'(o_frame_done), 64'(exp_frame));
                    pending_done = 0;
                end else if (o_tile_done || o_frame_done) begin
                    check("spurious_done", 64'({o_tile_done, o_frame_done}), 64'(0));
                end
                if (expect_write) check("strobe_gap", 64'(o_bram_en), 64'(1));
                expect_write = 0;
                if (o_bram_en) begin
                    check("we", 64'(o_bram_we), 64'(1));
                    check("ready_in_write", 64'(o_tile_ready), 64'(0));
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 64'(o_bram_en), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("addr", 64'(o_bram_addr), 64'(e.addr));
                        check("din", 64'(o_bram_din), 64'(e.data));
                        if (e.last) begin
                            pending_done = 1;
                            exp_frame    = e.frame;
                        end else begin
                            expect_write = 1;
                        end
                    end
                end else if (o_bram_we) begin
                    check("we_without_en", 64'(o_bram_we), 64'(0));
                end
            end
        end
    end

    initial begin
        logic [TW-1:0] d;
        int w;
        reset        = 1'b0;
        i_tile_valid = 1'b0;
        i_tile_data  = '0;
        #3;
        check_all_zero("reset");
        #19;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", 64'(o_tile_ready), 64'(1));

        // Known tile {1,2,3,-1}, then a full frame back-to-back plus one wrap tile.
        d = {29'h1FFFFFFF, 29'd3, 29'd2, 29'd1};
        send_tile(d, 1'b1);
        for (int i = 1; i < 17; i++) send_tile(rand_tile(), ($urandom_range(0, 1) == 1));

        for (int i = 0; i < 6; i++) begin
            gap($urandom_range(0, 4));
            send_tile(rand_tile(), ($urandom_range(0, 1) == 1));
        end

        // Reset after two writes of a tile: partial tile is dropped, next tile starts at 0.
        send_tile(rand_tile(), 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        tile_n = 0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_midreset", 64'(o_tile_ready), 64'(1));

        for (int i = 0; i < 20; i++) begin
            gap($urandom_range(0, 3));
            send_tile(rand_tile(), ($urandom_range(0, 1) == 1));
        end
        i_tile_valid = 1'b0;

        w = 0;
        while ((exp_q.size() != 0 || pending_done) && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("drain", 64'(exp_q.size()), 64'(0));
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/output_tile_writer.md
OUTPUT_TILE_WRITER -- requirements
Module: output_tile_writer

Interface
REQ-001 Parameter OUT_TILE, default 2: output tile edge (INPUT_TILE_SIZE-KERNEL_SIZE+1).
REQ-002 Parameter OUT_DATA_WIDTH, default 29: signed PE result width (8+8+13).
REQ-003 Parameter OUT_IMAGE_WIDTH, default 8; OUT_IMAGE_HEIGHT, default 8: output image size in pixels, each a multiple of OUT_TILE.
REQ-004 Parameter ADDR_WIDTH, default 15: output BRAM address width.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 i_tile_data  in  OUT_TILE*OUT_TILE*OUT_DATA_WIDTH  flattened PE output tile; element (r,c) at bits [(r*OUT_TILE+c)*OUT_DATA_WIDTH +: OUT_DATA_WIDTH].
REQ-009 i_tile_valid  in  1  tile present; held with stable data until accepted.
REQ-010 o_tile_ready  out  1  writer can accept a tile.
REQ-011 o_bram_en, o_bram_we  out  1 each  output BRAM port enable / write enable.
REQ-012 o_bram_addr  out  ADDR_WIDTH  write address; o_bram_din  out  OUT_DATA_WIDTH  write data.
REQ-013 o_tile_done  out  1  one-cycle pulse per tile fully written (drives proc_finish of the input interface).
REQ-014 o_frame_done  out  1  one-cycle pulse coincident with o_tile_done of the last tile of a frame.

Function
REQ-015 FSM states IDLE, WRITE, DONE; IDLE->WRITE on i_tile_valid&o_tile_ready at a rising edge; WRITE->DONE after last element; DONE->IDLE unconditionally.
REQ-016 o_tile_ready = 1 only in IDLE; i_tile_valid in WRITE/DONE ignored, no capture.
REQ-017 Handshake edge captures i_tile_data into an internal buffer; later changes of i_tile_data do not affect written values.
REQ-018 In WRITE, one element per cycle, k = 0..OUT_TILE^2-1 in order, o_bram_en=o_bram_we=1, o_bram_din = element k bit-exact (no saturation, no truncation).
REQ-019 Write strobes span exactly OUT_TILE^2 consecutive cycles starting the cycle after the handshake; outside WRITE o_bram_en=o_bram_we=0.
REQ-020 Address for element (r,c) of tile (tr,tc): (tr*OUT_TILE+r)*OUT_IMAGE_WIDTH + tc*OUT_TILE + c.
REQ-021 Tiles proceed raster order: tc increments per tile; at tc=OUT_IMAGE_WIDTH/OUT_TILE-1 tc wraps to 0, tr increments.
REQ-022 At last tile (both tr, tc at max) both wrap to 0; o_frame_done pulses in DONE with o_tile_done; next tile starts at address 0.
REQ-023 o_tile_done = 1 only in DONE (cycle after last write); minimum tile period OUT_TILE^2+2 cycles.
REQ-024 Tile position updates on DONE->IDLE transition only.

Reset
REQ-025 reset low clears, without clock: state IDLE, tr=tc=k=0, buffer 0; o_tile_ready=0 while reset low, 1 first cycle after release.
REQ-026 Reset values: o_bram_en=o_bram_we=0, o_bram_addr=0, o_bram_din=0, o_tile_done=o_frame_done=0.
REQ-027 Reset mid-WRITE discards the partial tile; no pulse; next accepted tile writes from address 0.

Structure
REQ-028 Shared package conv_pkg holds OUT_TILE, OUT_DATA_WIDTH derivations and FSM state encoding.
REQ-029 Sub-module output_addr_gen holds tr/tc/r/c counters and the REQ-020 address; writer FSM drives its step/wrap controls.

Verification (defaults)
REQ-030 Tile elements {1,2,3,-1} -> writes addr 0,1,8,9 data 1,2,3,0x1FFFFFFF over 4 cycles; o_tile_done next cycle; o_tile_ready cycle after.
REQ-031 Second tile -> addr 2,3,10,11; fifth tile -> addr 16,17,24,25.
REQ-032 16 back-to-back tiles -> 16th writes 54,55,62,63 with o_frame_done=o_tile_done=1; 17th writes 0,1,8,9.
REQ-033 i_tile_valid held high and i_tile_data changed during WRITE -> no extra capture, written values are the captured tile, o_tile_ready=0.
REQ-034 reset low after 2 writes -> all outputs 0 immediately, no o_tile_done; next tile writes 0,1,8,9.
